// File: rtl/bcd_down_counter_pkg.sv
// Shared constants, FSM state type and BCD digit clamp helper for the
// BCD down-counter.
package bcd_down_counter_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Digits 10..15 are not valid BCD; saturate them to 9.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        logic [3:0] r;
        if (d > BCD_MAX) begin
            r = BCD_MAX;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_down_counter_digit_dec.sv
// Single BCD digit decrementer. The digit wraps 0 -> 9 and raises a borrow
// for the next digit.
module bcd_digit_dec
    import bcd_down_counter_pkg::*;
(
    input  logic [3:0] d,
    input  logic       bin,
    output logic [3:0] q,
    output logic       bout
);

    // Decrement the digit when a borrow comes in from the lower digit.
    always_comb begin
        q    = d;
        bout = 1'b0;
        if (bin) begin
            if (d == 4'd0) begin
                q    = BCD_MAX;
                bout = 1'b1;
            end else begin
                q    = d - 4'd1;
                bout = 1'b0;
            end
        end else begin
            q    = d;
            bout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down-counter with a one-cycle borrow pulse at terminal count.
// Optional macro BCD_DOWN_COUNTER_AUTO_RELOAD_EN turns it into a mod-(N+1) reloading counter.
module bcd_down_counter
    import bcd_down_counter_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*DIGITS-1:0]     load_val,
    input  logic                    en,
    output logic [4*DIGITS-1:0]     cnt,
    output logic                    bout,
    output logic                    zero,
    output logic                    busy
);

    localparam int CW = BCD_W * DIGITS;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            bout_q, bout_d;
    logic [CW-1:0]   clamp_s;
    logic [CW-1:0]   dec_s;
    logic [DIGITS:0] borrow_s;
    logic            wrap_s;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
    logic [CW-1:0]   reload_q, reload_d;
`endif

    assign borrow_s[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            bcd_digit_dec u_dig (
                .d    (cnt_q[g*BCD_W +: BCD_W]),
                .bin  (borrow_s[g]),
                .q    (dec_s[g*BCD_W +: BCD_W]),
                .bout (borrow_s[g+1])
            );
        end
    endgenerate

    // A borrow out of the top digit means the count is already zero.
    assign wrap_s = borrow_s[DIGITS];

    // Saturate every load digit to a legal BCD value.
    always_comb begin
        clamp_s = {CW{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            clamp_s[i*BCD_W +: BCD_W] = bcd_clamp(load_val[i*BCD_W +: BCD_W]);
        end
    end

    // Next-state selection: load beats enable; enable only counts in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bout_d  = 1'b0;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            cnt_d   = clamp_s;
            bout_d  = 1'b0;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
            reload_d = clamp_s;
`endif
            if (clamp_s != {CW{1'b0}}) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_IDLE;
            end
        end else if ((state_q == ST_RUN) && en) begin
            if (wrap_s) begin
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
                cnt_d   = reload_q;
                state_d = ST_RUN;
`else
                cnt_d   = cnt_q;
                state_d = ST_IDLE;
`endif
            end else begin
                cnt_d = dec_s;
                if (dec_s == {CW{1'b0}}) begin
                    bout_d = 1'b1;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
                    state_d = ST_RUN;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    bout_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
        end else begin
            cnt_d   = cnt_q;
            bout_d  = 1'b0;
            state_d = state_q;
        end
    end

    // State, count and borrow registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            bout_q  <= 1'b0;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q <= {CW{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bout_q  <= bout_d;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign cnt  = cnt_q;
    assign bout = bout_q;
    assign busy = (state_q == ST_RUN);
    assign zero = (cnt_q == {CW{1'b0}});

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter: directed steps plus random
// traffic, compared every cycle against an integer-valued reference model.
module tb_bcd_down_counter;

    localparam int D  = 2;
    localparam int CW = 4 * D;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic [CW-1:0] load_val = '0;
    logic          en = 1'b0;
    logic [CW-1:0] cnt;
    logic          bout;
    logic          zero;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: plain decimal value, not BCD.
    int m_val    = 0;
    int m_reload = 0;
    bit m_run    = 1'b0;
    bit m_bout   = 1'b0;

    bcd_down_counter #(.DIGITS(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .cnt      (cnt),
        .bout     (bout),
        .zero     (zero),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int clamp_dec(input logic [CW-1:0] v);
        int r = 0;
        int w = 1;
        for (int i = 0; i < D; i++) begin
            int dg = int'(v[i*4 +: 4]);
            if (dg > 9) dg = 9;
            r += dg * w;
            w *= 10;
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] to_bcd(input int v);
        logic [CW-1:0] r = '0;
        int x = v;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_edge(input bit r, input bit ld, input logic [CW-1:0] lv, input bit e);
        if (r) begin
            m_val = 0; m_reload = 0; m_run = 1'b0; m_bout = 1'b0;
        end else if (ld) begin
            m_val = clamp_dec(lv); m_reload = m_val;
            m_run = (m_val != 0); m_bout = 1'b0;
        end else if (m_run && e) begin
            if (m_val == 0) begin
                m_val = m_reload; m_bout = 1'b0;
            end else begin
                m_val = m_val - 1;
                m_bout = (m_val == 0);
                if (m_val == 0 && !AUTO) m_run = 1'b0;
            end
        end else begin
            m_bout = 1'b0;
        end
    endtask

    task automatic step(input bit r, input bit ld, input logic [CW-1:0] lv, input bit e);
        rst = r; load = ld; load_val = lv; en = e;
        @(posedge clk);
        model_edge(r, ld, lv, e);
        #1;
        chk("cnt",  32'(cnt),  32'(to_bcd(m_val)));
        chk("bout", 32'(bout), 32'(m_bout));
        chk("busy", 32'(busy), 32'(m_run));
        chk("zero", 32'(zero), 32'(m_val == 0));
    endtask

    initial begin
        // Reset, then enable with nothing loaded.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_cnt", 32'(cnt), 32'h0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("idle_no_bout", 32'(bout), 32'h0);

        // Full countdown from 25.
        step(1'b0, 1'b1, 8'h25, 1'b0);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("pre_term_cnt", 32'(cnt), 32'h01);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("term_bout", 32'(bout), 32'h1);
        chk("term_cnt", 32'(cnt), 32'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Countdown from 10 with en toggling.
        step(1'b0, 1'b1, 8'h10, 1'b0);
        for (int i = 0; i < 22; i++) step(1'b0, 1'b0, 8'h00, (i % 2) == 0);

        // Invalid digit clamp, then zero load.
        step(1'b0, 1'b1, 8'hF3, 1'b0);
        chk("clamp_cnt", 32'(cnt), 32'h93);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("zero_load_busy", 32'(busy), 32'h0);

        // Load wins over en mid-count, then reset mid-count.
        step(1'b0, 1'b1, 8'h50, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("cnt47", 32'(cnt), 32'h47);
        step(1'b0, 1'b1, 8'h12, 1'b1);
        chk("reload12", 32'(cnt), 32'h12);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("cnt05", 32'(cnt), 32'h05);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // Short count from 3 over 12 enabled cycles (exercises auto-reload when built in).
        step(1'b0, 1'b1, 8'h03, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic, including invalid BCD loads.
        for (int i = 0; i < 600; i++) begin
            bit r  = ($urandom_range(0, 99) < 2);
            bit ld = ($urandom_range(0, 99) < 8);
            bit e  = ($urandom_range(0, 99) < 75);
            logic [CW-1:0] lv = CW'($urandom);
            if ($urandom_range(0, 3) == 0) lv = CW'($urandom_range(0, 4));
            step(r, ld, lv, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
